// File: rtl/communication_mode_sequencer.sv
// Sequences the shared UART/I2C pin pair through quiesce, drain, select flip and settle guard.
// Optional drain timeout is built when COMMSEL_DRAIN_TIMEOUT_EN is defined.
module communication_mode_sequencer #(
  parameter bit          ResetMode_Gen    = 1'b0,
  parameter int unsigned GuardCycles_Gen  = 100,
  parameter int unsigned DrainTimeout_Gen = 100000
) (
  input  logic SysClk_ClkIn,
  input  logic SysRst_RstIn,
  input  logic ModeReq_DatIn,
  input  logic UartBusy_DatIn,
  input  logic I2cBusy_DatIn,
  output logic Sel_DatOut,
  output logic UartEna_EnaOut,
  output logic I2cEna_EnaOut,
  output logic Switching_DatOut,
  output logic SwitchDone_ValOut,
  output logic Timeout_ValOut
);

  typedef enum logic [1:0] {
    IDLE_St  = 2'd0,
    DRAIN_St = 2'd1,
    GUARD_St = 2'd2
  } state_e;

  localparam logic [15:0] GuardLoad = 16'(GuardCycles_Gen - 1);

  state_e      state_q;
  logic        sel_q;
  logic        uart_ena_q;
  logic        i2c_ena_q;
  logic        switching_q;
  logic        done_q;
  logic [15:0] guard_q;
  logic        busy_out;
  logic        drain_expired;

  // The outgoing IP is always the one the mux currently selects.
  assign busy_out = sel_q ? I2cBusy_DatIn : UartBusy_DatIn;

`ifdef COMMSEL_DRAIN_TIMEOUT_EN
  localparam logic [23:0] DrainLast = 24'(DrainTimeout_Gen - 1);
  logic [23:0] drain_q;
  logic        timeout_q;

  assign drain_expired  = (drain_q == DrainLast);
  assign Timeout_ValOut = timeout_q;
`else
  logic unused_drain_cfg;

  assign unused_drain_cfg = (DrainTimeout_Gen == 0);
  assign drain_expired    = 1'b0;
  assign Timeout_ValOut   = 1'b0;
`endif

  always_ff @(posedge SysClk_ClkIn) begin
    if (SysRst_RstIn) begin
      state_q     <= IDLE_St;
      sel_q       <= ResetMode_Gen;
      uart_ena_q  <= ~ResetMode_Gen;
      i2c_ena_q   <= ResetMode_Gen;
      switching_q <= 1'b0;
      done_q      <= 1'b0;
      guard_q     <= 16'd0;
`ifdef COMMSEL_DRAIN_TIMEOUT_EN
      drain_q     <= 24'd0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef COMMSEL_DRAIN_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE_St: begin
          if (ModeReq_DatIn != sel_q) begin
            state_q     <= DRAIN_St;
            uart_ena_q  <= 1'b0;
            i2c_ena_q   <= 1'b0;
            switching_q <= 1'b1;
`ifdef COMMSEL_DRAIN_TIMEOUT_EN
            drain_q     <= 24'd0;
`endif
          end
        end
        DRAIN_St: begin
          // Abort wins over completion when both hold in the same cycle.
          if (ModeReq_DatIn == sel_q) begin
            state_q     <= IDLE_St;
            uart_ena_q  <= ~sel_q;
            i2c_ena_q   <= sel_q;
            switching_q <= 1'b0;
          end else if (!busy_out || drain_expired) begin
            state_q <= GUARD_St;
            sel_q   <= ~sel_q;
            guard_q <= GuardLoad;
`ifdef COMMSEL_DRAIN_TIMEOUT_EN
            timeout_q <= busy_out;
`endif
          end else begin
`ifdef COMMSEL_DRAIN_TIMEOUT_EN
            drain_q <= drain_q + 24'd1;
`endif
          end
        end
        GUARD_St: begin
          if (guard_q == 16'd0) begin
            state_q     <= IDLE_St;
            uart_ena_q  <= ~sel_q;
            i2c_ena_q   <= sel_q;
            switching_q <= 1'b0;
            done_q      <= 1'b1;
          end else begin
            guard_q <= guard_q - 16'd1;
          end
        end
        default: state_q <= IDLE_St;
      endcase
    end
  end

  assign Sel_DatOut        = sel_q;
  assign UartEna_EnaOut    = uart_ena_q;
  assign I2cEna_EnaOut     = i2c_ena_q;
  assign Switching_DatOut  = switching_q;
  assign SwitchDone_ValOut = done_q;

endmodule

// File: tb/tb_communication_mode_sequencer.sv
// Bench for communication_mode_sequencer: directed scenarios plus random traffic against
// a timestamp-based model of the switch sequence.
module tb_communication_mode_sequencer;

  localparam bit RESET_MODE = 1'b0;
  localparam int GUARD      = 4;
  localparam int DRAIN_TO   = 8;
`ifdef COMMSEL_DRAIN_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req = 1'b0;
  logic ub  = 1'b0;
  logic ib  = 1'b0;
  logic sel, uart_ena, i2c_ena, switching, done, tmo;

  always #5 clk = ~clk;

  communication_mode_sequencer #(
    .ResetMode_Gen    (RESET_MODE),
    .GuardCycles_Gen  (GUARD),
    .DrainTimeout_Gen (DRAIN_TO)
  ) dut (
    .SysClk_ClkIn      (clk),
    .SysRst_RstIn      (rst),
    .ModeReq_DatIn     (req),
    .UartBusy_DatIn    (ub),
    .I2cBusy_DatIn     (ib),
    .Sel_DatOut        (sel),
    .UartEna_EnaOut    (uart_ena),
    .I2cEna_EnaOut     (i2c_ena),
    .Switching_DatOut  (switching),
    .SwitchDone_ValOut (done),
    .Timeout_ValOut    (tmo)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_flip_cyc = -1;
  int last_done_cyc = -1;
  int last_to_cyc   = -1;
  logic prev_sel = RESET_MODE;

  // Model: a switch is "active" from request acceptance until done; the flip and the
  // end of the guard are located by elapsed cycle counts since drain start / flip.
  bit m_sel, m_active, m_flipped, m_done, m_to;
  int m_dstart, m_ftime;

  function automatic void model_step(input bit r, input bit q, input bit u, input bit i, input int n);
    bit busy;
    m_done = 1'b0;
    m_to   = 1'b0;
    if (r) begin
      m_sel = RESET_MODE; m_active = 1'b0; m_flipped = 1'b0;
      return;
    end
    if (!m_active) begin
      if (q != m_sel) begin
        m_active = 1'b1; m_flipped = 1'b0; m_dstart = n;
      end
    end else if (!m_flipped) begin
      busy = m_sel ? i : u;
      if (q == m_sel) m_active = 1'b0;
      else if (!busy || (TO_EN && (n - m_dstart) == DRAIN_TO)) begin
        m_to = busy; m_sel = ~m_sel; m_flipped = 1'b1; m_ftime = n;
      end
    end else if ((n - m_ftime) == GUARD) begin
      m_active = 1'b0; m_done = 1'b1;
    end
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input logic r, input logic q, input logic u, input logic i);
    rst = r; req = q; ub = u; ib = i;
    @(posedge clk);
    cyc++;
    model_step(r, q, u, i, cyc);
    #1;
    if (sel !== prev_sel) last_flip_cyc = cyc;
    if (done === 1'b1) last_done_cyc = cyc;
    if (tmo === 1'b1) last_to_cyc = cyc;
    prev_sel = sel;
    check_bit("sel", sel, m_sel);
    check_bit("uart_ena", uart_ena, !m_active && !m_sel);
    check_bit("i2c_ena", i2c_ena, !m_active && m_sel);
    check_bit("switching", switching, m_active);
    check_bit("switch_done", done, m_done);
    check_bit("timeout", tmo, m_to);
    check_bit("ena_exclusive", uart_ena & i2c_ena, 1'b0);
  endtask

  task automatic run(input int cnt, input logic r, input logic q, input logic u, input logic i);
    for (int k = 0; k < cnt; k++) tick(r, q, u, i);
  endtask

  initial begin
    int t0;
    int done_before;
    logic rq;

    // Reset
    run(2, 1'b1, 1'b0, 1'b0, 1'b0);
    check_bit("reset_sel", sel, 1'b0);
    check_bit("reset_uart_ena", uart_ena, 1'b1);
    run(2, 1'b0, 1'b0, 1'b0, 1'b0);

    // Clean UART->I2C switch, then back
    t0 = cyc + 1;
    run(8, 1'b0, 1'b1, 1'b0, 1'b0);
    check_int("clean_flip_latency", last_flip_cyc - t0, 1);
    check_int("clean_done_latency", last_done_cyc - t0, GUARD + 1);
    run(8, 1'b0, 1'b0, 1'b0, 1'b0);
    check_int("back_done_latency", last_done_cyc - t0, 8 + GUARD + 1);

    // UART busy for 10 extra cycles
    t0 = cyc + 1;
    run(11, 1'b0, 1'b1, 1'b1, 1'b0);
    run(8, 1'b0, 1'b1, 1'b0, 1'b0);
    check_int("busy_flip_latency", last_flip_cyc - t0, TO_EN ? DRAIN_TO : 11);
    check_int("busy_done_latency", last_done_cyc - t0, (TO_EN ? DRAIN_TO : 11) + GUARD);
    if (!TO_EN) check_int("busy_no_timeout", last_to_cyc, -1);
    run(8, 1'b0, 1'b0, 1'b0, 1'b0);

    // Abort during drain
    done_before = last_done_cyc;
    run(3, 1'b0, 1'b1, 1'b1, 1'b0);
    run(3, 1'b0, 1'b0, 1'b1, 1'b0);
    check_bit("abort_sel", sel, 1'b0);
    check_bit("abort_uart_ena", uart_ena, 1'b1);
    check_int("abort_no_done", last_done_cyc, done_before);
    run(2, 1'b0, 1'b0, 1'b0, 1'b0);

    // UART busy stuck at 1
    t0 = cyc + 1;
    run(20, 1'b0, 1'b1, 1'b1, 1'b0);
    if (TO_EN) begin
      check_int("stuck_timeout_cyc", last_to_cyc - t0, DRAIN_TO);
      check_int("stuck_flip_cyc", last_flip_cyc - t0, DRAIN_TO);
      check_int("stuck_done_cyc", last_done_cyc - t0, DRAIN_TO + GUARD);
    end else begin
      check_bit("stuck_no_flip", sel, 1'b0);
    end
    run(8, 1'b0, 1'b1, 1'b0, 1'b0);
    run(8, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset during guard
    run(3, 1'b0, 1'b1, 1'b0, 1'b0);
    check_bit("pre_reset_sel", sel, 1'b1);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    check_bit("guard_reset_sel", sel, RESET_MODE);
    check_bit("guard_reset_uart_ena", uart_ena, ~RESET_MODE);
    check_bit("guard_reset_switching", switching, 1'b0);
    run(10, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random traffic
    rq = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 7) == 0) rq = ~rq;
      tick(($urandom_range(0, 149) == 0), rq,
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/communication_mode_sequencer.md
# communication_mode_sequencer

Controls the mode change of the shared UART/I2C pin pair on the Time Card communication port. Runs on the system clock between the configuration register (requested mode) and the UART/I2C pin multiplexer. The pin multiplexer's select input is driven only from this block. A mode change follows a fixed sequence: quiesce the outgoing IP, wait for it to drain, flip the select, hold a bus-settle guard time, then enable the incoming IP.

## Interface
Parameters:
- ResetMode_Gen, 0: mode after reset (0 UART, 1 I2C).
- GuardCycles_Gen, 100: settle cycles after a select flip; legal range 1 to 2^16-1.
- DrainTimeout_Gen, 100000: maximum cycles spent in DRAIN; legal range 1 to 2^24-1; used only with the timeout feature.

Ports:
- SysClk_ClkIn  in  1  system clock; the block's only clock.
- SysRst_RstIn  in  1  synchronous, active-high reset.
- ModeReq_DatIn  in  1  requested mode level from config (0 UART, 1 I2C); synchronous to SysClk.
- UartBusy_DatIn  in  1  UART IP has a transfer in progress or its TX is not empty.
- I2cBusy_DatIn  in  1  I2C IP transaction in progress.
- Sel_DatOut  out  1  select input for the pin multiplexer.
- UartEna_EnaOut  out  1  UART IP enable.
- I2cEna_EnaOut  out  1  I2C IP enable.
- Switching_DatOut  out  1  high while a mode change is in progress.
- SwitchDone_ValOut  out  1  one-cycle pulse when the new mode is enabled.
- Timeout_ValOut  out  1  one-cycle pulse when the drain phase was forced to end.

## Operation
- States: IDLE_St, DRAIN_St, GUARD_St. All outputs are registered.
- Reset values:
  - state IDLE_St.
  - Sel_DatOut = ResetMode_Gen.
  - UartEna_EnaOut = not ResetMode_Gen; I2cEna_EnaOut = ResetMode_Gen.
  - Switching_DatOut, SwitchDone_ValOut and Timeout_ValOut all 0.
  - All counters 0.
- IDLE_St:
  - If ModeReq_DatIn ≠ Sel_DatOut, go to DRAIN_St. In the same update, set both enables to 0, set Switching to 1 and clear the drain counter.
  - Otherwise hold.
- DRAIN_St:
  - The outgoing IP is the one selected by the current Sel_DatOut; its busy input is the one checked.
  - Abort: if ModeReq_DatIn = Sel_DatOut again, return to IDLE_St. Restore the old enable, set Switching to 0, and do not pulse SwitchDone. Abort takes priority over completion in the same cycle.
  - Completion: if the outgoing busy input is 0, toggle Sel_DatOut, load the guard counter with GuardCycles_Gen-1 and go to GUARD_St.
  - Otherwise increment the drain counter (timeout behaviour is under Configuration).
- GUARD_St:
  - Both enables stay 0. ModeReq changes are ignored (no abort).
  - If the guard counter = 0: go to IDLE_St, set the enable matching the new Sel_DatOut to 1, set Switching to 0 and pulse SwitchDone for one cycle.
  - Otherwise decrement the guard counter.
- Both enables are never 1 at the same time. An enable is never 1 while Sel_DatOut mismatches it.
- A ModeReq change during GUARD_St is acted on only after the return to IDLE_St, which starts a new sequence.
- Reset asserted in any state returns every register to its reset value on the next edge, even mid-switch. Sel then returns to ResetMode_Gen.

## Timing
- Request mismatch sampled at edge 0, with the outgoing IP already idle:
  - DRAIN_St and both enables 0 from edge 1.
  - Sel flips at edge 2.
  - GUARD_St spans edges 2 to GuardCycles_Gen+1.
  - New enable and SwitchDone pulse at edge GuardCycles_Gen+2.
- Minimum switch latency is GuardCycles_Gen+2 cycles. Each cycle of outgoing busy adds one cycle.
- Busy inputs are used as synchronous levels. Metastability protection is not part of this block.

## Configuration
- COMMSEL_DRAIN_TIMEOUT_EN defined:
  - A 24-bit drain counter is built.
  - If DRAIN_St has lasted DrainTimeout_Gen cycles (counter = DrainTimeout_Gen-1) and busy is still 1, the completion branch is forced.
  - Timeout_ValOut pulses on the same edge that Sel flips. The sequence then continues normally, including the SwitchDone pulse.
- Not defined:
  - DRAIN_St waits on busy without limit.
  - Timeout_ValOut is tied to 0 and the drain counter is not built.

## Test plan
- Reset with ResetMode_Gen=0: Sel=0, UartEna=1, I2cEna=0, Switching=0.
- GuardCycles_Gen=4, both busy 0, ModeReq 0→1:
  - enables 0 one cycle later; Sel=1 two cycles later.
  - I2cEna=1 and SwitchDone pulse 6 cycles after the request.
  - No cycle with both enables 1.
- UartBusy held 1 for 10 cycles after the request: Sel flip is delayed exactly 10 cycles and no Timeout pulse occurs.
- ModeReq 0→1, then back to 0 while in DRAIN_St with UartBusy=1: return to IDLE, UartEna=1, Sel stays 0, no SwitchDone.
- With COMMSEL_DRAIN_TIMEOUT_EN, DrainTimeout_Gen=8 and UartBusy stuck at 1: Timeout pulse and Sel flip 8 cycles after DRAIN entry, followed by SwitchDone.
- Reset asserted during GUARD_St: next cycle Sel=ResetMode_Gen, reset enables restored and Switching=0.
